// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_unit
// Purpose  : Owns the MIPS HI/LO register pair and sequences all HI/LO
//            instructions in the EX stage. Multiplies run on an internal
//            iterative shift-add multiplier. Divides are launched on an
//            external multi-cycle divider, and its results are captured.
//            MF/MT moves are stalled while a result is still pending.
// Ports    : clock, reset (async, active-low)
//            OP_mult/OP_multu/OP_div/OP_divu - start ops (abort pending op)
//            OP_mthi/OP_mtlo/OP_mfhi/OP_mflo - register moves
//            Rs_data, Rt_data                 - operands / move-to data
//            Div_Quotient, Div_Remainder,
//            Div_Stall                        - external divider results/busy
//            Div_OP_div, Div_OP_divu,
//            Div_Dividend, Div_Divisor        - divider launch (passthrough)
//            HILO_Out                         - MFHI/MFLO read data
//            Stall                            - pipeline hold request
// Revision : 1.0 - initial release
// ============================================================================
module hilo_unit #(
   parameter int MUL_LOG2_BPC = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        OP_mult,
   input  logic        OP_multu,
   input  logic        OP_div,
   input  logic        OP_divu,
   input  logic        OP_mthi,
   input  logic        OP_mtlo,
   input  logic        OP_mfhi,
   input  logic        OP_mflo,
   input  logic [31:0] Rs_data,
   input  logic [31:0] Rt_data,
   input  logic [31:0] Div_Quotient,
   input  logic [31:0] Div_Remainder,
   input  logic        Div_Stall,
   output logic        Div_OP_div,
   output logic        Div_OP_divu,
   output logic [31:0] Div_Dividend,
   output logic [31:0] Div_Divisor,
   output logic [31:0] HILO_Out,
   output logic        Stall
);

   localparam int         BPC      = 1 << MUL_LOG2_BPC;
   localparam int         MUL_CYC  = 32 >> MUL_LOG2_BPC;
   localparam logic [4:0] CNT_INIT = 5'(MUL_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [63:0] acc_q, acc_d;
   logic [63:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        neg_q, neg_d;
   logic        rneg_q, rneg_d;
   logic        first_q, first_d;

   logic        start_mul;
   logic        start_div;
   logic        move_op;
   logic        busy;
   logic [31:0] rs_mag;
   logic [31:0] rt_mag;
   logic [63:0] pp;
   logic [63:0] acc_sum;
   logic [63:0] mul_res;

   // Divider launch is a pure passthrough; the divider decides when to start.
   assign Div_OP_div   = OP_div;
   assign Div_OP_divu  = OP_divu;
   assign Div_Dividend = Rs_data;
   assign Div_Divisor  = Rt_data;

   assign start_mul = OP_mult | OP_multu;
   assign start_div = OP_div | OP_divu;
   assign move_op   = OP_mfhi | OP_mflo | OP_mthi | OP_mtlo;
   assign busy      = (state_q != S_IDLE);
   assign Stall     = move_op & busy;

   // Reads come straight from the registers: no bypass of an in-flight write.
   assign HILO_Out  = OP_mfhi ? hi_q : (OP_mflo ? lo_q : 32'd0);

   // Magnitudes for signed multiply; 0x80000000 maps onto itself, which is
   // the correct unsigned magnitude.
   assign rs_mag = (OP_mult && Rs_data[31]) ? (32'd0 - Rs_data) : Rs_data;
   assign rt_mag = (OP_mult && Rt_data[31]) ? (32'd0 - Rt_data) : Rt_data;

   // Partial product for the low BPC multiplier bits.
   always_comb begin
      pp = 64'd0;
      for (int i = 0; i < BPC; i++) begin
         if (mplier_q[i]) begin
            pp = pp + (mcand_q << i);
         end
      end
   end

   assign acc_sum = acc_q + pp;
   assign mul_res = neg_q ? (64'd0 - acc_sum) : acc_sum;

   always_comb begin
      state_d  = state_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      first_d  = first_q;

      if (start_mul) begin
         // New multiply aborts whatever was pending; HI/LO untouched.
         state_d  = S_MUL;
         mcand_d  = {32'd0, rs_mag};
         mplier_d = rt_mag;
         acc_d    = 64'd0;
         cnt_d    = CNT_INIT;
         neg_d    = OP_mult & (Rs_data[31] ^ Rt_data[31]);
      end else if (start_div) begin
         state_d = S_DIV;
         rneg_d  = OP_div & Rs_data[31];
         first_d = 1'b1;
      end else if (!busy && OP_mthi) begin
         hi_d = Rs_data;
      end else if (!busy && OP_mtlo) begin
         lo_d = Rs_data;
      end else begin
         case (state_q)
            S_MUL: begin
               acc_d    = acc_sum;
               mcand_d  = mcand_q << BPC;
               mplier_d = mplier_q >> BPC;
               cnt_d    = cnt_q - 5'd1;
               if (cnt_q == 5'd0) begin
                  {hi_d, lo_d} = mul_res;
                  state_d      = S_IDLE;
               end
            end
            S_DIV: begin
               // Div_Stall is not yet valid in the launch+1 cycle, so the
               // first cycle in DIV never counts as completion.
               first_d = 1'b0;
               if (!first_q && !Div_Stall) begin
                  lo_d    = Div_Quotient;
                  hi_d    = rneg_q ? (32'd0 - Div_Remainder) : Div_Remainder;
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         acc_q    <= 64'd0;
         mcand_q  <= 64'd0;
         mplier_q <= 32'd0;
         cnt_q    <= 5'd0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         first_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         first_q  <= first_d;
      end
   end

endmodule
`default_nettype wire
